// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the mux scan sequencer: FSM encoding, default sizes,
// and a clog2 helper for sizing the settle counter.
package mux_scan_pkg;

  localparam int DEF_NUM_CH = 16;
  localparam int DEF_SEL_W  = 4;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_SCAN = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mux_scan_capture.sv
// Per-channel capture register plus the held output word (and parity when
// MUX_SCAN_PARITY_EN is defined).
module mux_scan_capture
  import mux_scan_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int SEL_W  = DEF_SEL_W
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_clear,
  input  logic              i_cap_en,
  input  logic [SEL_W-1:0]  i_cap_idx,
  input  logic              i_cap_bit,
  input  logic              i_load,
  output logic [NUM_CH-1:0] o_data
`ifdef MUX_SCAN_PARITY_EN
  , output logic            o_parity
`endif
);

  logic [NUM_CH-1:0] r_cap;
  logic [NUM_CH-1:0] w_cap_next;

  // The last channel's bit is folded in combinationally so the output word is
  // complete on the same edge that captures it.
  always_comb begin
    w_cap_next = r_cap;
    if (i_cap_en) w_cap_next[i_cap_idx] = i_cap_bit;
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_cap  <= '0;
      o_data <= '0;
    end else begin
      if (i_clear)       r_cap <= '0;
      else if (i_cap_en) r_cap <= w_cap_next;
      if (i_load) o_data <= w_cap_next;
    end
  end

`ifdef MUX_SCAN_PARITY_EN
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset)     o_parity <= 1'b0;
    else if (i_load) o_parity <= ^w_cap_next;
  end
`endif

endmodule

// File: rtl/mux_scan_sequencer.sv
// Walks a 16:1 bit mux across NUM_CH channels, assembles one bit per channel into a
// word, and offers it on a valid/ready port. Optional parity via MUX_SCAN_PARITY_EN.
module mux_scan_sequencer
  import mux_scan_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int SEL_W  = DEF_SEL_W,
  parameter int SETTLE = 0
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic              i_mux_in,
  output logic [SEL_W-1:0]  o_mux_sel,
  output logic              o_mux_enable,
  output logic              o_busy,
  output logic [NUM_CH-1:0] o_out_data,
  output logic              o_out_valid,
  input  logic              i_out_ready
`ifdef MUX_SCAN_PARITY_EN
  , output logic            o_out_parity
`endif
);

  localparam int CNT_W = (clog2(SETTLE + 1) < 1) ? 1 : clog2(SETTLE + 1);
  localparam logic [CNT_W-1:0] SETTLE_TC = CNT_W'(SETTLE);
  localparam logic [SEL_W-1:0] LAST_IDX  = SEL_W'(NUM_CH - 1);

  state_t           r_state;
  logic [SEL_W-1:0] r_idx;
  logic [CNT_W-1:0] r_settle;
  logic             r_mux_en;
  logic             r_out_valid;

  logic w_settle_done;
  logic w_capture;
  logic w_last;
  logic w_accept;
  logic w_launch;

  assign w_settle_done = (r_settle == SETTLE_TC);
  assign w_capture     = (r_state == ST_SCAN) && !i_abort && w_settle_done;
  assign w_last        = w_capture && (r_idx == LAST_IDX);
  assign w_accept      = (r_state == ST_DONE) && r_out_valid && i_out_ready;
  // abort beats start in IDLE; abort has no say once the frame is complete
  assign w_launch      = ((r_state == ST_IDLE) && i_start && !i_abort) ||
                         (w_accept && i_start);

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_settle    <= '0;
      r_mux_en    <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_launch) begin
            r_state  <= ST_SCAN;
            r_idx    <= '0;
            r_settle <= '0;
            r_mux_en <= 1'b1;
          end
        end
        ST_SCAN: begin
          if (i_abort) begin
            r_state  <= ST_IDLE;
            r_idx    <= '0;
            r_settle <= '0;
            r_mux_en <= 1'b0;
          end else if (w_settle_done) begin
            r_settle <= '0;
            if (w_last) begin
              r_state     <= ST_DONE;
              r_idx       <= '0;
              r_mux_en    <= 1'b0;
              r_out_valid <= 1'b1;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end else begin
            r_settle <= r_settle + 1'b1;
          end
        end
        ST_DONE: begin
          if (w_accept) begin
            r_out_valid <= 1'b0;
            if (w_launch) begin
              r_state  <= ST_SCAN;
              r_mux_en <= 1'b1;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_idx       <= '0;
          r_settle    <= '0;
          r_mux_en    <= 1'b0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  // idx is forced to 0 outside SCAN, so it doubles as the registered select.
  assign o_mux_sel    = r_idx;
  assign o_mux_enable = r_mux_en;
  assign o_busy       = (r_state != ST_IDLE);
  assign o_out_valid  = r_out_valid;

  mux_scan_capture #(
    .NUM_CH (NUM_CH),
    .SEL_W  (SEL_W)
  ) u_capture (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .i_clear   (w_launch),
    .i_cap_en  (w_capture),
    .i_cap_idx (r_idx),
    .i_cap_bit (i_mux_in),
    .i_load    (w_last),
    .o_data    (o_out_data)
`ifdef MUX_SCAN_PARITY_EN
    , .o_parity (o_out_parity)
`endif
  );

endmodule
